sprite_rom_arbiter: RTL
=======================

Name: sprite_rom_arbiter

Overview:
- Time-multiplexes one shared single-port sprite ROM/SRAM read port among N_REQ pixel-address requesters (e.g. player, computer, ball).
- Each VGA pixel period gets one read slot per requester. Returned pixels are presented to the colour mux together, one pixel later.
- Sits between the per-sprite address generators and the shared sprite memory. Lets the display path drop duplicated sprite BRAMs.

Parameters:
- N_REQ, 3, number of requesters/slots per pixel.
- ADDR_W, 18, memory address width.
- DATA_W, 12, pixel width (RGB 4:4:4).
- MEM_LAT, 1, memory read latency in clk cycles (address registered -> data valid).
- TRANSPARENT, 12'h0f0, pixel value returned for idle or failed slots.

Ports:
- clk  in  1  system clock (100 MHz)
- reset_n  in  1  asynchronous, active-low reset
- pixel_tick  in  1  one-clk pulse per pixel period; min spacing N_REQ+MEM_LAT+1 clk
- req_valid  in  N_REQ  per-requester "pixel inside sprite region"
- req_addr  in  N_REQ*ADDR_W  per-requester address, lane k at [k*ADDR_W +: ADDR_W]
- mem_en  out  1  memory read enable
- mem_addr  out  ADDR_W  memory address
- mem_data  in  DATA_W  memory read data, valid MEM_LAT clk after mem_en
- rd_data  out  N_REQ*DATA_W  per-lane pixel output, lane k at [k*DATA_W +: DATA_W]
- rd_valid  out  N_REQ  lane k carries real memory data
- busy  out  1  issue/drain sequence in progress
- overrun  out  1  sticky: pixel_tick arrived before sequence completed
- overrun_clr  in  1  synchronous clear of overrun

Behaviour:
- Reset (async, reset_n=0):
  - state=IDLE; mem_en=0, mem_addr=0, busy=0, overrun=0, rd_valid=0.
  - Every rd_data lane = TRANSPARENT.
  - Snapshot and staging registers cleared: valids 0, data TRANSPARENT.
- FSM states:
  - IDLE: no pixel_tick seen since reset.
  - ISSUE: slot counter s = 0..N_REQ-1.
  - DRAIN: MEM_LAT cycles.
  - DONE: waiting for the next tick.
- On pixel_tick (any state):
  - Capture req_valid/req_addr into snapshot registers.
  - Present the previous staging results: rd_data/rd_valid <= staging, updated atomically in the same edge.
  - Clear staging to TRANSPARENT/0.
  - Go to ISSUE with s=0.
  - Requester inputs may change freely after the tick edge.
- ISSUE, each clk, slot s:
  - mem_en <= snap_valid[s]; mem_addr <= snap_valid[s] ? snap_addr[s] : 0.
  - s increments.
  - After s=N_REQ-1, go to DRAIN.
  - Fixed lane order 0 first; no priority inversion, every lane gets exactly one slot per pixel.
- Capture: a delay line of width $clog2(N_REQ)+1 tags each issued slot. MEM_LAT clk after the slot's mem_en, staging[s] <= mem_data and staging_valid[s] <= 1. Slots issued with mem_en=0 keep TRANSPARENT/0.
- DRAIN → DONE after the last capture.
- mem_en returns to 0 in DRAIN/DONE/IDLE; mem_addr holds 0.
- busy = 1 in ISSUE and DRAIN only.
- Latency: pixel requested at tick n appears on rd_data right after tick n+1. Fixed one-pixel pipeline delay; the upstream pixel counters compensate.
- Overrun (pixel_tick while ISSUE or DRAIN):
  - overrun <= 1.
  - Unfinished lanes are presented as TRANSPARENT with rd_valid=0; completed lanes are presented normally.
  - In-flight captures are discarded via a flush of the tag pipe.
  - The new sequence starts immediately.
- overrun_clr and an overrun event in the same cycle: overrun=1 (set wins).
- First pixel_tick after reset presents all-TRANSPARENT, rd_valid=0.
- Widths: slot counter $clog2(N_REQ) bits, no wrap beyond N_REQ-1; addresses pass unmodified (no arithmetic).
- reset_n deasserted mid-sequence: everything aborts to reset values immediately; no memory read is issued until the next pixel_tick.

Test Plan:
- Reset, then tick every 8 clk with req_valid=3'b111, addrs 0x10/0x20/0x30; memory model data=addr[11:0] → after 2nd tick rd_data lanes = 0x010/0x020/0x030, rd_valid=3'b111, mem_en pulses 3 consecutive clk per pixel.
- req_valid=3'b010, addr1=0x1A5 → only one mem_en pulse per pixel, addr 0x1A5; rd_data lane0/lane2 = 0x0F0, lane1 = 0x1A5, rd_valid=3'b010.
- Change req_addr the clk after tick → outputs reflect addresses sampled at the tick only.
- Ticks spaced 3 clk (N_REQ=3, MEM_LAT=1) → overrun=1 sticky, lane2 presented 0x0F0 with rd_valid[2]=0; overrun_clr pulse with 8-clk spacing → overrun=0; clr coincident with an overrun → overrun stays 1.
- MEM_LAT=2 build, 8-clk ticks → same data as scenario 1, busy high exactly 5 clk per pixel.
- Assert reset_n=0 during ISSUE slot 1 → mem_en=0, rd_valid=0, lanes 0x0F0 immediately; no mem_en until next pixel_tick.

Source files
------------

// File: rtl/sprite_rom_arbiter.sv
// Shares one single-port sprite memory read port among N_REQ requesters by giving
// each requester one read slot per pixel period; results are presented one pixel later.
module sprite_rom_arbiter #(
  parameter int                N_REQ       = 3,
  parameter int                ADDR_W      = 18,
  parameter int                DATA_W      = 12,
  parameter int                MEM_LAT     = 1,
  parameter logic [DATA_W-1:0] TRANSPARENT = 12'h0f0
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      pixel_tick,
  input  logic [N_REQ-1:0]          req_valid,
  input  logic [N_REQ*ADDR_W-1:0]   req_addr,
  output logic                      mem_en,
  output logic [ADDR_W-1:0]         mem_addr,
  input  logic [DATA_W-1:0]         mem_data,
  output logic [N_REQ*DATA_W-1:0]   rd_data,
  output logic [N_REQ-1:0]          rd_valid,
  output logic                      busy,
  output logic                      overrun,
  input  logic                      overrun_clr
);

  localparam int SLOT_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int TAG_W  = SLOT_W + 1;
  localparam int DCNT_W = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ISSUE = 2'd1;
  localparam logic [1:0] DRAIN = 2'd2;
  localparam logic [1:0] DONE  = 2'd3;

  localparam logic [SLOT_W-1:0] LAST_SLOT  = SLOT_W'(N_REQ - 1);
  localparam logic [DCNT_W-1:0] LAST_DRAIN = DCNT_W'(MEM_LAT - 1);

  logic [1:0]              state;
  logic [SLOT_W-1:0]       slot;
  logic [DCNT_W-1:0]       drain_cnt;
  logic [N_REQ-1:0]        snap_valid;
  logic [N_REQ*ADDR_W-1:0] snap_addr;
  logic [N_REQ-1:0]        stage_valid;
  logic [N_REQ*DATA_W-1:0] stage_data;
  logic [TAG_W-1:0]        tag_pipe [MEM_LAT];

  logic                    cur_valid;
  logic [ADDR_W-1:0]       cur_addr;
  logic [TAG_W-1:0]        issue_tag;
  logic                    cap_hit;
  logic [SLOT_W-1:0]       cap_slot;
  logic [N_REQ-1:0]        stage_valid_next;
  logic [N_REQ*DATA_W-1:0] stage_data_next;

  assign busy = (state == ISSUE) || (state == DRAIN);

  always_comb begin
    cur_valid = 1'b0;
    cur_addr  = '0;
    for (int k = 0; k < N_REQ; k++) begin
      if (slot == SLOT_W'(k)) begin
        cur_valid = snap_valid[k];
        cur_addr  = snap_addr[k*ADDR_W +: ADDR_W];
      end
    end
    issue_tag = (state == ISSUE) ? {cur_valid, slot} : '0;
  end

  assign cap_hit  = tag_pipe[MEM_LAT-1][TAG_W-1];
  assign cap_slot = tag_pipe[MEM_LAT-1][SLOT_W-1:0];

  // A capture landing on a tick edge still counts as completed, so it is merged
  // here and forwarded straight to the presented outputs.
  always_comb begin
    stage_valid_next = stage_valid;
    stage_data_next  = stage_data;
    for (int k = 0; k < N_REQ; k++) begin
      if (cap_hit && (cap_slot == SLOT_W'(k))) begin
        stage_valid_next[k]                  = 1'b1;
        stage_data_next[k*DATA_W +: DATA_W] = mem_data;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      slot      <= '0;
      drain_cnt <= '0;
      mem_en    <= 1'b0;
      mem_addr  <= '0;
    end else if (pixel_tick) begin
      state     <= ISSUE;
      slot      <= '0;
      drain_cnt <= '0;
      mem_en    <= 1'b0;
      mem_addr  <= '0;
    end else begin
      mem_en   <= 1'b0;
      mem_addr <= '0;
      case (state)
        ISSUE: begin
          mem_en   <= cur_valid;
          mem_addr <= cur_valid ? cur_addr : '0;
          if (slot == LAST_SLOT) begin
            state     <= DRAIN;
            drain_cnt <= '0;
          end else begin
            slot <= slot + SLOT_W'(1);
          end
        end
        DRAIN: begin
          if (drain_cnt == LAST_DRAIN) begin
            state <= DONE;
          end else begin
            drain_cnt <= drain_cnt + DCNT_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  // The tick flushes the tag pipe so reads still in flight never land in the new pixel.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < MEM_LAT; i++) tag_pipe[i] <= '0;
    end else if (pixel_tick) begin
      for (int i = 0; i < MEM_LAT; i++) tag_pipe[i] <= '0;
    end else begin
      tag_pipe[0] <= issue_tag;
      for (int i = 1; i < MEM_LAT; i++) tag_pipe[i] <= tag_pipe[i-1];
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      snap_valid  <= '0;
      snap_addr   <= '0;
      stage_valid <= '0;
      stage_data  <= {N_REQ{TRANSPARENT}};
      rd_valid    <= '0;
      rd_data     <= {N_REQ{TRANSPARENT}};
      overrun     <= 1'b0;
    end else if (pixel_tick) begin
      snap_valid  <= req_valid;
      snap_addr   <= req_addr;
      rd_valid    <= stage_valid_next;
      rd_data     <= stage_data_next;
      stage_valid <= '0;
      stage_data  <= {N_REQ{TRANSPARENT}};
      if (busy) begin
        overrun <= 1'b1;
      end else if (overrun_clr) begin
        overrun <= 1'b0;
      end
    end else begin
      stage_valid <= stage_valid_next;
      stage_data  <= stage_data_next;
      if (overrun_clr) begin
        overrun <= 1'b0;
      end
    end
  end

endmodule
